// File: rtl/mode_controller.sv
// Mode/adjust/alarm sequencing FSM for the clock front panel.
// Turns debounced button pulses and time ticks into field selects, step strobes and alarm ringing.
`timescale 1ns/1ps

module mode_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_c,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       alarm_sw,
    input  logic       sec_tick,
    input  logic       min_tick,
    input  logic       time_eq_alarm,
    output logic       adjust,
    output logic       ENTH,
    output logic       ENTM,
    output logic       sel_alarm,
    output logic       step,
    output logic       updown,
    output logic       buzzer,
    output logic       blink,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        CLOCK  = 3'd0,
        ADJ_TH = 3'd1,
        ADJ_TM = 3'd2,
        ADJ_AH = 3'd3,
        ADJ_AM = 3'd4,
        RING   = 3'd5
    } state_t;

    state_t     cur_st;
    state_t     nxt_st;
    logic [4:0] adj_tmr;
    logic [4:0] adj_tmr_nxt;
    logic [5:0] ring_tmr;
    logic [5:0] ring_tmr_nxt;

    logic adjust_nxt;
    logic enth_nxt;
    logic entm_nxt;
    logic sel_alarm_nxt;
    logic step_nxt;
    logic updown_nxt;
    logic buzzer_nxt;
    logic blink_nxt;

    logic any_btn;
    logic cur_adj;
    logic nxt_adj;
    logic alarm_hit;
    logic adj_timeout;
    logic ring_done;

    function automatic logic is_adj(input state_t s);
        return (s == ADJ_TH) || (s == ADJ_TM) || (s == ADJ_AH) || (s == ADJ_AM);
    endfunction

    function automatic state_t field_next(input state_t s);
        case (s)
            ADJ_TH:  return ADJ_TM;
            ADJ_TM:  return ADJ_AH;
            ADJ_AH:  return ADJ_AM;
            default: return ADJ_TH;
        endcase
    endfunction

    function automatic state_t field_prev(input state_t s);
        case (s)
            ADJ_TH:  return ADJ_AM;
            ADJ_AM:  return ADJ_AH;
            ADJ_AH:  return ADJ_TM;
            default: return ADJ_TH;
        endcase
    endfunction

    assign any_btn     = btn_c | btn_l | btn_r | btn_u | btn_d;
    assign cur_adj     = is_adj(cur_st);
    assign nxt_adj     = is_adj(nxt_st);
    assign alarm_hit   = min_tick & time_eq_alarm & alarm_sw;
    // A button in the same cycle as the 30th tick clears the count instead of timing out.
    assign adj_timeout = cur_adj & ~any_btn & sec_tick & (adj_tmr == 5'd29);
    assign ring_done   = sec_tick & (ring_tmr == 6'd59);
    assign state       = cur_st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_st    <= CLOCK;
            adj_tmr   <= '0;
            ring_tmr  <= '0;
            adjust    <= 1'b0;
            ENTH      <= 1'b0;
            ENTM      <= 1'b0;
            sel_alarm <= 1'b0;
            step      <= 1'b0;
            updown    <= 1'b0;
            buzzer    <= 1'b0;
            blink     <= 1'b0;
        end else begin
            cur_st    <= nxt_st;
            adj_tmr   <= adj_tmr_nxt;
            ring_tmr  <= ring_tmr_nxt;
            adjust    <= adjust_nxt;
            ENTH      <= enth_nxt;
            ENTM      <= entm_nxt;
            sel_alarm <= sel_alarm_nxt;
            step      <= step_nxt;
            updown    <= updown_nxt;
            buzzer    <= buzzer_nxt;
            blink     <= blink_nxt;
        end
    end

    always_comb begin
        nxt_st        = cur_st;
        adj_tmr_nxt   = '0;
        ring_tmr_nxt  = '0;
        step_nxt      = 1'b0;
        updown_nxt    = updown;
        blink_nxt     = 1'b0;
        adjust_nxt    = 1'b0;
        enth_nxt      = 1'b0;
        entm_nxt      = 1'b0;
        sel_alarm_nxt = 1'b0;
        buzzer_nxt    = 1'b0;

        case (cur_st)
            CLOCK: begin
                if (alarm_hit) begin
                    nxt_st = RING;
                end else if (btn_c) begin
                    nxt_st = ADJ_TH;
                end
            end
            ADJ_TH, ADJ_TM, ADJ_AH, ADJ_AM: begin
                if (btn_c) begin
                    nxt_st = CLOCK;
                end else if (btn_r & ~btn_l) begin
                    nxt_st = field_next(cur_st);
                end else if (btn_l & ~btn_r) begin
                    nxt_st = field_prev(cur_st);
                end else if (adj_timeout) begin
                    nxt_st = CLOCK;
                end
            end
            RING: begin
                if (any_btn | ~alarm_sw | ring_done) begin
                    nxt_st = CLOCK;
                end
            end
            default: nxt_st = CLOCK;
        endcase

        // Up/down only acts when no higher-priority button is present; back-to-back strobes are suppressed.
        if (cur_adj & ~btn_c & ~btn_l & ~btn_r & (btn_u ^ btn_d) & ~step) begin
            step_nxt   = 1'b1;
            updown_nxt = btn_d;
        end

        if (nxt_adj) begin
            blink_nxt = cur_adj ? (blink ^ sec_tick) : 1'b1;
            if (cur_adj & ~any_btn) begin
                adj_tmr_nxt = sec_tick ? adj_tmr + 5'd1 : adj_tmr;
            end
        end

        if ((cur_st == RING) && (nxt_st == RING)) begin
            ring_tmr_nxt = sec_tick ? ring_tmr + 6'd1 : ring_tmr;
        end

        adjust_nxt    = nxt_adj;
        enth_nxt      = (nxt_st == ADJ_TH) || (nxt_st == ADJ_AH);
        entm_nxt      = (nxt_st == ADJ_TM) || (nxt_st == ADJ_AM);
        sel_alarm_nxt = (nxt_st == ADJ_AH) || (nxt_st == ADJ_AM);
        buzzer_nxt    = (nxt_st == RING);
    end

endmodule
